// File: rtl/posit_soc_pkg.sv
// Shared definitions for the posit SoC glue logic.
//   state_t        : batch sequencer FSM states
//   DATA_W_DEF     : default posit word / RAM data width
//   ADDR_W_DEF     : default RAM word-address width
//   pair_addr()    : word address of operand pair i, base + 2*i
package posit_soc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD1      = 3'd1,
        RD2      = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        WRITE    = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Computed at 32 bits; callers truncate to their address width, which
    // gives the modulo-2^ADDR_W wrap for free.
    function automatic logic [31:0] pair_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx << 1);
    endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Synchroniser plus rising-edge detector for a slow level input (PIO bit).
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_level : asynchronous level input
//   o_rise  : one-cycle pulse on a 0->1 transition of the synchronised level
// STAGES must be at least 2.
module pulse_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_level};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/posit_mem_sequencer.sv
// Batch sequencer: reads operand pairs from RAM A, feeds them to the posit
// unit and writes each result to RAM B.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : PIO level, rising edge launches a batch
//   count/src_base/dst_base : batch size, first pair address, first result address
//   busy/done/err/ops_done  : PIO status (done and err are sticky)
//   a_*                 : RAM A read port (s2)
//   b_*                 : RAM B write port
//   num1/num2/op_valid/op_ready : operand handshake to the posit unit
//   result/res_valid    : result return, res_valid is a one-cycle pulse
//   dbg_state           : current FSM state
// Handshake: an operand transfer happens on a clock edge where op_valid and
// op_ready are both high; op_valid, num1 and num2 stay constant from the
// first cycle op_valid rises until that edge.
module posit_mem_sequencer
    import posit_soc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     count,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     ops_done,
    output logic [ADDR_W-1:0]     a_address,
    output logic                  a_chipselect,
    output logic                  a_clken,
    input  logic [DATA_W-1:0]     a_readdata,
    output logic [ADDR_W-1:0]     b_address,
    output logic                  b_chipselect,
    output logic                  b_write,
    output logic [DATA_W-1:0]     b_writedata,
    output logic [DATA_W/8-1:0]   b_byteenable,
    output logic [DATA_W-1:0]     num1,
    output logic [DATA_W-1:0]     num2,
    output logic                  op_valid,
    input  logic                  op_ready,
    input  logic [DATA_W-1:0]     result,
    input  logic                  res_valid,
    output logic [2:0]            dbg_state
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_lat;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;
    logic [DATA_W-1:0]   r_num1;
    logic [DATA_W-1:0]   r_num2;
    logic [DATA_W-1:0]   r_result;

    logic                w_start_rise;
    logic                w_accept;
    logic                w_lat_done;
    logic                w_tmo_hit;
    logic [ADDR_W-1:0]   w_idx_inc;
    logic [ADDR_W-1:0]   w_pair_addr;

    pulse_edge_detect #(.STAGES(2)) u_start_edge (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_level (start),
        .o_rise  (w_start_rise)
    );

    // Edges while a batch runs are dropped, not queued.
    assign w_accept    = w_start_rise && ((r_state == IDLE) || (r_state == DONE));
    // The read address is held for RD_LAT+1 cycles; data is sampled in the last.
    assign w_lat_done  = (r_lat == 2'(RD_LAT));
    assign w_tmo_hit   = (TIMEOUT != 0) && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_idx_inc   = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_pair_addr = ADDR_W'(pair_addr(32'(r_src), 32'(r_idx)));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_accept) w_next = (count == '0) ? DONE : RD1;
            RD1:        if (w_lat_done) w_next = RD2;
            RD2:        if (w_lat_done) w_next = ISSUE;
            ISSUE:      if (op_ready) w_next = WAIT_RES;
            WAIT_RES: begin
                // A result arriving on the timeout cycle still wins.
                if (res_valid)      w_next = WRITE;
                else if (w_tmo_hit) w_next = DONE;
            end
            WRITE:      w_next = (w_idx_inc == r_count) ? DONE : RD1;
            default:    w_next = IDLE;
        endcase
    end

    // Batch registers, counters and captured data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_idx    <= '0;
            r_lat    <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_num1   <= '0;
            r_num2   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_count <= count;
                r_src   <= src_base;
                r_dst   <= dst_base;
                r_idx   <= '0;
                r_err   <= 1'b0;
            end
            if ((r_state == RD1) || (r_state == RD2)) begin
                r_lat <= w_lat_done ? 2'd0 : r_lat + 2'd1;
            end else begin
                r_lat <= 2'd0;
            end
            if ((r_state == RD1) && w_lat_done) r_num1 <= a_readdata;
            if ((r_state == RD2) && w_lat_done) r_num2 <= a_readdata;
            if (r_state == WAIT_RES) begin
                r_tmo <= r_tmo + TMO_W'(1);
                if (res_valid)      r_result <= result;
                else if (w_tmo_hit) r_err    <= 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (r_state == WRITE) r_idx <= w_idx_inc;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy         = (r_state != IDLE) && (r_state != DONE);
        done         = (r_state == DONE);
        err          = r_err;
        ops_done     = r_idx;
        dbg_state    = r_state;
        num1         = r_num1;
        num2         = r_num2;
        a_address    = '0;
        a_chipselect = 1'b0;
        a_clken      = 1'b0;
        b_address    = '0;
        b_chipselect = 1'b0;
        b_write      = 1'b0;
        b_writedata  = '0;
        b_byteenable = '0;
        op_valid     = 1'b0;
        case (r_state)
            RD1: begin
                a_address    = w_pair_addr;
                a_chipselect = 1'b1;
                a_clken      = 1'b1;
            end
            RD2: begin
                a_address    = w_pair_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                a_chipselect = 1'b1;
                a_clken      = 1'b1;
            end
            ISSUE: op_valid = 1'b1;
            WRITE: begin
                b_address    = r_dst + r_idx;
                b_chipselect = 1'b1;
                b_write      = 1'b1;
                b_writedata  = r_result;
                b_byteenable = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_posit_mem_sequencer.sv
module tb_posit_mem_sequencer;
  import posit_soc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 11;

  // ---------------- clock / reset / DUT signals ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] count = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          busy, done, err;
  logic [AW-1:0] ops_done;
  logic [AW-1:0] a_address;
  logic          a_chipselect, a_clken;
  logic [DW-1:0] a_readdata = '0;
  logic [AW-1:0] b_address;
  logic          b_chipselect, b_write;
  logic [DW-1:0] b_writedata;
  logic [DW/8-1:0] b_byteenable;
  logic [DW-1:0] num1, num2;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [DW-1:0] result = '0;
  logic          res_valid = 1'b0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  posit_mem_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .count(count),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
    .err(err), .ops_done(ops_done), .a_address(a_address),
    .a_chipselect(a_chipselect), .a_clken(a_clken), .a_readdata(a_readdata),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_write(b_write),
    .b_writedata(b_writedata), .b_byteenable(b_byteenable), .num1(num1),
    .num2(num2), .op_valid(op_valid), .op_ready(op_ready), .result(result),
    .res_valid(res_valid), .dbg_state(dbg_state)
  );

  // ---------------- models: RAM A (1-cycle read) and posit unit ----------------
  logic [DW-1:0] ram_a [0:2047];
  logic          unit_mute = 1'b0;

  always @(posedge clk) begin
    if (a_chipselect && a_clken) a_readdata <= ram_a[a_address];
  end

  // Hand-computed posit16 (es=1) sums for the main pairs; raw add otherwise.
  function automatic logic [DW-1:0] unit_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [2*DW-1:0] key;
    key = {x, y};
    case (key)
      32'h4000_4000: return 16'h5000;  // 1.0 + 1.0 = 2.0
      32'h5000_3000: return 16'h5400;  // 2.0 + 0.5 = 2.5
      32'h7000_4000: return 16'h7040;  // 16.0 + 1.0 = 17.0
      default:       return x + y;
    endcase
  endfunction

  always @(posedge clk) begin
    res_valid <= 1'b0;
    if (op_valid && op_ready && !unit_mute) begin
      res_valid <= 1'b1;
      result    <= unit_add(num1, num2);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  logic [AW-1:0]    addr_log[$];
  int b_writes = 0;
  int a_cs_cycles = 0;
  int handshakes = 0;
  int wait_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  always @(negedge clk) begin
    if (a_chipselect) begin
      a_cs_cycles++;
      addr_log.push_back(a_address);
    end
    if (op_valid && op_ready) handshakes++;
    if (dbg_state == 3'(WAIT_RES)) wait_cnt++;
    if (b_write) begin
      b_writes++;
      chk("b_write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("b_address", 32'(b_address), 32'(mon_e[AW+DW-1:DW]));
        chk("b_writedata", 32'(b_writedata), 32'(mon_e[DW-1:0]));
        chk("b_byteenable", 32'(b_byteenable), 32'h3);
        chk("b_chipselect", 32'(b_chipselect), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_batch(input logic [AW-1:0] cnt, input logic [AW-1:0] sb,
                           input logic [AW-1:0] db, output int cyc, output logic saw_busy);
    count = cnt; src_base = sb; dst_base = db;
    start = 1'b1;
    cyc = 0; saw_busy = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy) saw_busy = 1'b1;
      if (done && (saw_busy || cnt == '0)) break;
    end
    chk("batch_done_seen", 32'(done), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, n, hs0, bw0, cs0;
    logic sb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    chk("rst_a_cs", 32'(a_chipselect), 0);
    chk("rst_b_write", 32'(b_write), 0);
    chk("rst_b_be", 32'(b_byteenable), 0);
    chk("rst_op_valid", 32'(op_valid), 0);
    chk("rst_num1", 32'(num1), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    op_ready = 1'b1;
    repeat (2) @(negedge clk);

    // count = 0: done one cycle after the synchronised edge (2 sync + 1)
    cs0 = a_cs_cycles; bw0 = b_writes;
    run_batch(0, 0, 0, cyc, sb);
    chk("zero_cycles", 32'(cyc), 3);
    chk("zero_busy_never", 32'(sb), 0);
    chk("zero_err", 32'(err), 0);
    chk("zero_ops_done", 32'(ops_done), 0);
    chk("zero_a_cs", 32'(a_cs_cycles - cs0), 0);
    chk("zero_b_write", 32'(b_writes - bw0), 0);

    // Main batch: three pairs, results to 0x10..0x12, 7 cycles per op
    ram_a[0] = 16'h4000; ram_a[1] = 16'h4000;
    ram_a[2] = 16'h5000; ram_a[3] = 16'h3000;
    ram_a[4] = 16'h7000; ram_a[5] = 16'h4000;
    push_exp(11'h010, 16'h5000);
    push_exp(11'h011, 16'h5400);
    push_exp(11'h012, 16'h7040);
    addr_log.delete();
    hs0 = handshakes; bw0 = b_writes;
    run_batch(3, 11'h000, 11'h010, cyc, sb);
    chk("main_cycles", 32'(cyc), 3 + 3 * 7);
    chk("main_err", 32'(err), 0);
    chk("main_busy", 32'(busy), 0);
    chk("main_ops_done", 32'(ops_done), 3);
    chk("main_writes", 32'(b_writes - bw0), 3);
    chk("main_handshakes", 32'(handshakes - hs0), 3);
    chk("main_exp_left", 32'(exp_q.size()), 0);
    chk("main_rd_beats", 32'(addr_log.size()), 12);
    chk("main_addr0", 32'(addr_log[0]), 32'h000);
    chk("main_addr2", 32'(addr_log[2]), 32'h001);
    chk("main_addr4", 32'(addr_log[4]), 32'h002);
    chk("main_addr11", 32'(addr_log[11]), 32'h005);
    chk("main_idle_a_cs", 32'(a_chipselect), 0);

    // Backpressure: op_ready low for 5 cycles
    ram_a[11'h020] = 16'h1234; ram_a[11'h021] = 16'h0101;
    push_exp(11'h030, 16'h1335);
    op_ready = 1'b0;
    hs0 = handshakes;
    count = 1; src_base = 11'h020; dst_base = 11'h030;
    start = 1'b1;
    n = 0;
    while (!op_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(op_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(op_valid), 1);
      chk("bp_num1_held", 32'(num1), 32'h1234);
      chk("bp_num2_held", 32'(num2), 32'h0101);
      @(negedge clk);
    end
    op_ready = 1'b1;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("bp_done", 32'(done), 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_handshakes", 32'(handshakes - hs0), 1);
    chk("bp_ops_done", 32'(ops_done), 1);
    chk("bp_exp_left", 32'(exp_q.size()), 0);

    // Address wrap on both RAMs
    ram_a[11'h7FF] = 16'h2222; ram_a[0] = 16'h0303;
    ram_a[1] = 16'h0010;       ram_a[2] = 16'h0020;
    push_exp(11'h7FF, 16'h2525);
    push_exp(11'h000, 16'h0030);
    addr_log.delete();
    run_batch(2, 11'h7FF, 11'h7FF, cyc, sb);
    chk("wrap_cycles", 32'(cyc), 3 + 2 * 7);
    chk("wrap_rd_beats", 32'(addr_log.size()), 8);
    chk("wrap_addr0", 32'(addr_log[0]), 32'h7FF);
    chk("wrap_addr2", 32'(addr_log[2]), 32'h000);
    chk("wrap_addr4", 32'(addr_log[4]), 32'h001);
    chk("wrap_addr6", 32'(addr_log[6]), 32'h002);
    chk("wrap_ops_done", 32'(ops_done), 2);
    chk("wrap_exp_left", 32'(exp_q.size()), 0);

    // Timeout: unit never answers
    ram_a[11'h050] = 16'h0001; ram_a[11'h051] = 16'h0002;
    unit_mute = 1'b1;
    wait_cnt = 0; bw0 = b_writes;
    run_batch(2, 11'h050, 11'h060, cyc, sb);
    chk("tmo_cycles", 32'(cyc), 3 + 5 + 16);
    chk("tmo_wait_cycles", 32'(wait_cnt), 16);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_done", 32'(done), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_ops_done", 32'(ops_done), 0);
    chk("tmo_no_write", 32'(b_writes - bw0), 0);
    unit_mute = 1'b0;

    // Second start edge mid-batch is ignored
    ram_a[0] = 16'h4000; ram_a[1] = 16'h4000; ram_a[2] = 16'h5000;
    push_exp(11'h070, 16'h5000);
    push_exp(11'h071, 16'h5400);
    push_exp(11'h072, 16'h7040);
    bw0 = b_writes;
    count = 3; src_base = 0; dst_base = 11'h070;
    start = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("mid_busy_seen", 32'(busy), 1);
    chk("mid_err_cleared", 32'(err), 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("mid_done", 32'(done), 1);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_after", 32'(busy), 0);
    chk("mid_ops_done", 32'(ops_done), 3);
    chk("mid_writes", 32'(b_writes - bw0), 3);
    chk("mid_exp_left", 32'(exp_q.size()), 0);

    // Reset mid-batch: outputs drop asynchronously, no further writes
    push_exp(11'h080, 16'h5000);
    bw0 = b_writes;
    count = 3; src_base = 0; dst_base = 11'h080;
    start = 1'b1;
    n = 0;
    while (!(busy && ops_done == 11'd1) && n < 100) begin @(negedge clk); n++; end
    chk("rmid_first_op", 32'(ops_done), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_done", 32'(done), 0);
    chk("rmid_ops_done", 32'(ops_done), 0);
    chk("rmid_a_cs", 32'(a_chipselect), 0);
    chk("rmid_a_addr", 32'(a_address), 0);
    chk("rmid_state", 32'(dbg_state), 32'(IDLE));
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rmid_writes", 32'(b_writes - bw0), 1);
    chk("rmid_exp_left", 32'(exp_q.size()), 0);

    // Clean batch after reset
    push_exp(11'h090, 16'h5000);
    run_batch(1, 0, 11'h090, cyc, sb);
    chk("post_cycles", 32'(cyc), 3 + 7);
    chk("post_err", 32'(err), 0);
    chk("post_ops_done", 32'(ops_done), 1);
    chk("post_exp_left", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
